// File: rtl/ddr3_fe_pkg.sv
// Shared types for the DDR3 request front end.
//   fe_state_e : issue FSM states
//   fe_cmd_e   : kind of command latched for the controller
//   fe_entry_t : request FIFO entry at the default widths {we, addr, wdata}
package ddr3_fe_pkg;

  localparam int FE_ADDR_W = 26;
  localparam int FE_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD,
    ST_WAIT_BUSY,
    ST_WAIT_DATA
  } fe_state_e;

  typedef enum logic [1:0] {
    CMD_RD,
    CMD_WR,
    CMD_REF
  } fe_cmd_e;

  typedef struct packed {
    logic                 we;
    logic [FE_ADDR_W-1:0] addr;
    logic [FE_DATA_W-1:0] wdata;
  } fe_entry_t;

  function automatic fe_cmd_e req_cmd(input logic we);
    return we ? CMD_WR : CMD_RD;
  endfunction

endpackage

// File: rtl/ddr3_fe_fifo.sv
// Synchronous request FIFO (first-word fall-through read port).
//   pclk/rst   : clock, synchronous active-high reset
//   push/wdata : write an entry (ignored while full, even if popping)
//   pop/rdata  : rdata is the head entry; pop removes it (ignored while empty)
//   full/empty : occupancy flags from an explicit counter
module ddr3_fe_fifo #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 4
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);  // power-of-two depth: wraps naturally
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/ddr3_req_frontend.sv
// Client front end for ddr3_controller (pclk domain).
// Buffers client requests, issues them one at a time honouring ctl_busy,
// injects periodic auto-refresh, and returns read data (or a timeout) in order.
//   client side : req_valid/req_ready/req_we/req_addr/req_wdata,
//                 rsp_valid/rsp_rdata/rsp_timeout
//   controller  : ctl_addr/ctl_din/ctl_rd/ctl_wr/ctl_refresh (out),
//                 ctl_dout/ctl_data_ready/ctl_busy (in)
//   status      : refresh_overrun (sticky until rst)
module ddr3_req_frontend
  import ddr3_fe_pkg::*;
#(
  parameter int ADDR_WIDTH     = 26,
  parameter int DATA_WIDTH     = 16,
  parameter int DEPTH          = 4,
  parameter int REFRESH_CYCLES = 780,
  parameter int RD_TIMEOUT     = 32
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  init_done,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic                  refresh_overrun,
  output logic [ADDR_WIDTH-1:0] ctl_addr,
  output logic [DATA_WIDTH-1:0] ctl_din,
  output logic                  ctl_rd,
  output logic                  ctl_wr,
  output logic                  ctl_refresh,
  input  logic [DATA_WIDTH-1:0] ctl_dout,
  input  logic                  ctl_data_ready,
  input  logic                  ctl_busy
);

  localparam int ENT_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int REF_W = $clog2(REFRESH_CYCLES);
  localparam int RD_W  = $clog2(RD_TIMEOUT + 1);
  localparam logic [REF_W-1:0] REF_LOAD = REF_W'(REFRESH_CYCLES - 1);
  localparam logic [RD_W-1:0]  RD_LAST  = RD_W'(RD_TIMEOUT - 1);

  // FIFO
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [ENT_W-1:0] fifo_rdata;
  logic                  head_we;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;

  assign req_ready = !fifo_full && !rst;
  assign {head_we, head_addr, head_wdata} = fifo_rdata;

  ddr3_fe_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .pclk  (pclk),
    .rst   (rst),
    .push  (req_valid && req_ready),
    .wdata ({req_we, req_addr, req_wdata}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State
  fe_state_e             state_q, state_d;
  fe_cmd_e               cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [REF_W-1:0]      ref_cnt_q, ref_cnt_d;
  logic                  ref_pend_q, ref_pend_d;
  logic                  overrun_q, overrun_d;
  logic [RD_W-1:0]       rd_cnt_q, rd_cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  ref_clr;

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    din_d         = din_q;
    ref_cnt_d     = ref_cnt_q;
    ref_pend_d    = ref_pend_q;
    overrun_d     = overrun_q;
    rd_cnt_d      = rd_cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    fifo_pop      = 1'b0;
    ref_clr       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (init_done && !ctl_busy && (ref_pend_q || !fifo_empty)) begin
          state_d = ST_ISSUE;
          if (ref_pend_q) begin
            // Refresh wins; addr/din keep their last issued values.
            cmd_d = CMD_REF;
          end else begin
            cmd_d    = req_cmd(head_we);
            addr_d   = head_addr;
            din_d    = head_wdata;
            fifo_pop = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (cmd_q == CMD_REF) ref_clr = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // Controller may not have raised busy yet, so it is not looked at here.
        rd_cnt_d = '0;
        state_d  = (cmd_q == CMD_RD) ? ST_WAIT_DATA : ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!ctl_busy) state_d = ST_IDLE;
      end
      ST_WAIT_DATA: begin
        if (ctl_data_ready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ctl_dout;
          state_d     = ST_WAIT_BUSY;
        end else if (rd_cnt_q == RD_LAST) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = ST_WAIT_BUSY;
        end else begin
          rd_cnt_d = rd_cnt_q + RD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Refresh timer. A new expiry sets ref_pend even in the cycle the previous
    // one is being issued; it only counts as an overrun if that earlier
    // refresh is not going out this cycle.
    if (ref_clr) ref_pend_d = 1'b0;
    if (init_done) begin
      if (ref_cnt_q == '0) begin
        ref_cnt_d  = REF_LOAD;
        ref_pend_d = 1'b1;
        if (ref_pend_q && !ref_clr) overrun_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q - REF_W'(1);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cmd_q         <= CMD_RD;
      addr_q        <= '0;
      din_q         <= '0;
      ref_cnt_q     <= REF_LOAD;
      ref_pend_q    <= 1'b0;
      overrun_q     <= 1'b0;
      rd_cnt_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      din_q         <= din_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_pend_q    <= ref_pend_d;
      overrun_q     <= overrun_d;
      rd_cnt_q      <= rd_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  assign ctl_rd          = (state_q == ST_ISSUE) && (cmd_q == CMD_RD);
  assign ctl_wr          = (state_q == ST_ISSUE) && (cmd_q == CMD_WR);
  assign ctl_refresh     = (state_q == ST_ISSUE) && (cmd_q == CMD_REF);
  assign ctl_addr        = addr_q;
  assign ctl_din         = din_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_timeout     = rsp_timeout_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign refresh_overrun = overrun_q;

endmodule
